// File: rtl/led_display_scan_controller.sv
// rtl/led_display_scan_controller.sv - BCM scan sequencer between frame buffer, LED phy and panel OE
// Each row/plane pass: fetch, push to phy, wait for latch, then show for a binary-weighted time.
module led_display_scan_controller #(
  parameter int BIT_DEPTH      = 8,
  parameter int BASE_ON_CYCLES = 4,
  parameter int NUM_ROWS       = 16,
  parameter int NUM_COLS       = 32
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  enable_in,
  output logic                  fb_req_out,
  output logic [3:0]            fb_row_out,
  output logic [2:0]            fb_plane_out,
  input  logic                  fb_valid_in,
  input  logic [6*NUM_COLS-1:0] fb_data_in,
  output logic                  row_valid_out,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic [3:0]            row_address_out,
  input  logic                  row_ready_in,
  input  logic                  latch_in,
  output logic                  oe_n_out,
  output logic                  frame_done_out,
  output logic [15:0]           frame_count_out
);

  localparam int ROW_W = 6 * NUM_COLS;
  localparam int CNT_W = $clog2(BASE_ON_CYCLES << (BIT_DEPTH - 1)) + 1;
  localparam logic [2:0]       LAST_PLANE = 3'(BIT_DEPTH - 1);
  localparam logic [3:0]       LAST_ROW   = 4'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] BASE_CNT   = CNT_W'(BASE_ON_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_LOAD,
    S_SHIFT,
    S_SHOW,
    S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        row_idx_q, row_idx_d;
  logic [2:0]        plane_q, plane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fb_req_q, fb_req_d;
  logic [3:0]        fb_row_q, fb_row_d;
  logic [2:0]        fb_plane_q, fb_plane_d;
  logic              row_valid_q, row_valid_d;
  logic [ROW_W-1:0]  row_data_q, row_data_d;
  logic [3:0]        row_address_q, row_address_d;
  logic              oe_n_q, oe_n_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    row_idx_d     = row_idx_q;
    plane_d       = plane_q;
    cnt_d         = cnt_q;
    fb_req_d      = 1'b0;
    fb_row_d      = fb_row_q;
    fb_plane_d    = fb_plane_q;
    row_valid_d   = 1'b0;
    row_data_d    = row_data_q;
    row_address_d = row_address_q;
    oe_n_d        = 1'b1;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          row_idx_d = 4'd0;
          plane_d   = 3'd0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        fb_req_d   = 1'b1;
        fb_row_d   = row_idx_q;
        fb_plane_d = plane_q;
        state_d    = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (fb_valid_in) begin
          row_data_d = fb_data_in;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (row_ready_in) begin
          row_valid_d   = 1'b1;
          row_address_d = row_idx_q;
          state_d       = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The counter holds remaining SHOW cycles minus one, so OE lasts exactly BASE << plane.
        if (latch_in) begin
          cnt_d   = (BASE_CNT << plane_q) - CNT_W'(1);
          oe_n_d  = 1'b0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          oe_n_d = 1'b0;
        end
      end
      S_NEXT: begin
        state_d = S_FETCH;
        if (plane_q == LAST_PLANE) begin
          plane_d = 3'd0;
          if (row_idx_q == LAST_ROW) begin
            row_idx_d     = 4'd0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (!enable_in) state_d = S_IDLE;
          end else begin
            row_idx_d = row_idx_q + 4'd1;
          end
        end else begin
          plane_d = plane_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q       <= S_IDLE;
      row_idx_q     <= 4'd0;
      plane_q       <= 3'd0;
      cnt_q         <= '0;
      fb_req_q      <= 1'b0;
      fb_row_q      <= 4'd0;
      fb_plane_q    <= 3'd0;
      row_valid_q   <= 1'b0;
      row_data_q    <= '0;
      row_address_q <= 4'd0;
      oe_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      plane_q       <= plane_d;
      cnt_q         <= cnt_d;
      fb_req_q      <= fb_req_d;
      fb_row_q      <= fb_row_d;
      fb_plane_q    <= fb_plane_d;
      row_valid_q   <= row_valid_d;
      row_data_q    <= row_data_d;
      row_address_q <= row_address_d;
      oe_n_q        <= oe_n_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign fb_req_out      = fb_req_q;
  assign fb_row_out      = fb_row_q;
  assign fb_plane_out    = fb_plane_q;
  assign row_valid_out   = row_valid_q;
  assign row_out         = row_data_q;
  assign row_address_out = row_address_q;
  assign oe_n_out        = oe_n_q;
  assign frame_done_out  = frame_done_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_led_display_scan_controller.sv
// tb/tb_led_display_scan_controller.sv - randomized bench for the LED scan controller
// Frame buffer and phy are behavioural models; expected scan order is rebuilt from nested loops.
module tb_led_display_scan_controller;

  localparam int BD   = 2;
  localparam int BASE = 2;
  localparam int NR   = 2;
  localparam int NC   = 4;
  localparam int W    = 6 * NC;

  logic          clk = 1'b0;
  logic          n_reset_in;
  logic          enable_in;
  logic          fb_req_out;
  logic [3:0]    fb_row_out;
  logic [2:0]    fb_plane_out;
  logic          fb_valid_in;
  logic [W-1:0]  fb_data_in;
  logic          row_valid_out;
  logic [W-1:0]  row_out;
  logic [3:0]    row_address_out;
  logic          row_ready_in;
  logic          latch_in;
  logic          oe_n_out;
  logic          frame_done_out;
  logic [15:0]   frame_count_out;

  led_display_scan_controller #(
    .BIT_DEPTH(BD), .BASE_ON_CYCLES(BASE), .NUM_ROWS(NR), .NUM_COLS(NC)
  ) dut (
    .clk_in(clk), .n_reset_in(n_reset_in), .enable_in(enable_in),
    .fb_req_out(fb_req_out), .fb_row_out(fb_row_out), .fb_plane_out(fb_plane_out),
    .fb_valid_in(fb_valid_in), .fb_data_in(fb_data_in),
    .row_valid_out(row_valid_out), .row_out(row_out), .row_address_out(row_address_out),
    .row_ready_in(row_ready_in), .latch_in(latch_in), .oe_n_out(oe_n_out),
    .frame_done_out(frame_done_out), .frame_count_out(frame_count_out)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mem [NR][BD];
  int           fb_delay   = 1;
  bit           spur_valid = 1'b0;
  bit           spur_latch = 1'b0;
  int           rsp_row, rsp_plane;
  logic [6:0]   req_q [$];
  logic [3:0]   addr_q [$];
  logic [W-1:0] data_q [$];
  int           oe_q [$];
  int           oe_run = 0;
  int           frames_seen = 0;
  logic [15:0]  exp_fc = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (fb_req_out) req_q.push_back({fb_row_out, fb_plane_out});
    if (row_valid_out) begin
      addr_q.push_back(row_address_out);
      data_q.push_back(row_out);
    end
    if (!oe_n_out) oe_run++;
    else if (oe_run > 0) begin
      oe_q.push_back(oe_run);
      oe_run = 0;
    end
    if (frame_done_out) frames_seen++;
  end

  // Frame buffer: answers each request after fb_delay cycles; optionally one stray valid during SHOW.
  always @(negedge clk) begin
    if (fb_req_out) begin
      rsp_row   = int'(fb_row_out) % NR;
      rsp_plane = int'(fb_plane_out) % BD;
      repeat (fb_delay) @(negedge clk);
      fb_data_in  = mem[rsp_row][rsp_plane];
      fb_valid_in = 1'b1;
      @(negedge clk);
      fb_valid_in = 1'b0;
      fb_data_in  = '0;
    end else if (spur_valid && !oe_n_out) begin
      fb_data_in  = W'($urandom);
      fb_valid_in = 1'b1;
      @(negedge clk);
      fb_valid_in = 1'b0;
      fb_data_in  = '0;
      spur_valid  = 1'b0;
    end
  end

  // Phy: latches NC+1 cycles after a row push; optionally one stray latch during SHOW.
  always @(negedge clk) begin
    if (row_valid_out) begin
      repeat (NC + 1) @(negedge clk);
      latch_in = 1'b1;
      @(negedge clk);
      latch_in = 1'b0;
    end else if (spur_latch && !oe_n_out) begin
      latch_in = 1'b1;
      @(negedge clk);
      latch_in   = 1'b0;
      spur_latch = 1'b0;
    end
  end

  task automatic clear_logs();
    req_q.delete();
    addr_q.delete();
    data_q.delete();
    oe_q.delete();
    oe_run      = 0;
    frames_seen = 0;
  endtask

  task automatic run_frames(input int nframes, input int delay, input bit bp, input bit spur);
    int cyc;
    int nreq;
    int np;
    int idx;
    clear_logs();
    for (int r = 0; r < NR; r++)
      for (int p = 0; p < BD; p++) mem[r][p] = W'($urandom);
    fb_delay   = delay;
    spur_valid = spur;
    spur_latch = spur;
    if (bp) row_ready_in = 1'b0;
    @(negedge clk);
    enable_in = 1'b1;
    @(negedge clk);
    if (nframes == 1) enable_in = 1'b0;

    if (bp) begin
      cyc = 0;
      do begin
        @(posedge clk);
        cyc++;
      end while (fb_valid_in !== 1'b1 && cyc < 200);
      check("bp_data_arrived", 32'(cyc < 200), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        check("bp_no_push", row_valid_out, 1'b0);
        check("bp_row_stable", row_out, mem[0][0]);
        @(negedge clk);
      end
      row_ready_in = 1'b1;
      @(negedge clk);
      check("bp_push_first_ready", row_valid_out, 1'b1);
    end

    if (nframes > 1) begin
      cyc = 0;
      while (frames_seen < nframes - 1 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      enable_in = 1'b0;
    end

    cyc = 0;
    while (frames_seen < nframes && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_timeout", 32'(frames_seen >= nframes), 32'd1);

    nreq = req_q.size();
    repeat (30) @(negedge clk);
    check("idle_no_req", req_q.size(), nreq);
    check("idle_oe_off", oe_n_out, 1'b1);
    check("frame_done_cnt", frames_seen, nframes);
    exp_fc = exp_fc + 16'(nframes);
    check("frame_count", frame_count_out, exp_fc);

    np = nframes * NR * BD;
    check("req_count", req_q.size(), np);
    check("push_count", addr_q.size(), np);
    check("oe_count", oe_q.size(), np);
    idx = 0;
    for (int f = 0; f < nframes; f++)
      for (int r = 0; r < NR; r++)
        for (int p = 0; p < BD; p++) begin
          if (idx < req_q.size()) check("req_order", req_q[idx], {4'(r), 3'(p)});
          if (idx < addr_q.size()) begin
            check("push_addr", addr_q[idx], r);
            check("push_data", data_q[idx], mem[r][p]);
          end
          if (idx < oe_q.size()) check("oe_len", oe_q[idx], BASE << p);
          idx++;
        end
    spur_valid   = 1'b0;
    spur_latch   = 1'b0;
    row_ready_in = 1'b1;
  endtask

  initial begin
    int cyc;
    n_reset_in   = 1'b1;
    enable_in    = 1'b0;
    fb_valid_in  = 1'b0;
    fb_data_in   = '0;
    row_ready_in = 1'b1;
    latch_in     = 1'b0;
    #3 n_reset_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", oe_n_out, 1'b1);
    check("rst_req", fb_req_out, 1'b0);
    check("rst_push", row_valid_out, 1'b0);
    check("rst_row", row_out, '0);
    check("rst_count", frame_count_out, 16'd0);
    check("rst_done", frame_done_out, 1'b0);
    n_reset_in = 1'b1;

    run_frames(1, 1, 1'b0, 1'b0);
    run_frames(2, 1, 1'b0, 1'b0);
    run_frames(1, 5, 1'b0, 1'b1);
    run_frames(1, 2, 1'b1, 1'b0);

    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_count_q;
    exp_fc = 16'hFFFF;
    run_frames(1, 1, 1'b0, 1'b0);

    clear_logs();
    enable_in = 1'b1;
    cyc = 0;
    while (oe_n_out !== 1'b0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_show", oe_n_out, 1'b0);
    #2 n_reset_in = 1'b0;
    #1;
    check("rst_async_oe", oe_n_out, 1'b1);
    check("rst_async_req", fb_req_out, 1'b0);
    check("rst_async_push", row_valid_out, 1'b0);
    check("rst_async_count", frame_count_out, 16'd0);
    enable_in = 1'b0;
    repeat (3) @(negedge clk);
    n_reset_in = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    check("post_rst_no_req", req_q.size(), 0);
    check("post_rst_no_push", addr_q.size(), 0);
    check("post_rst_oe", oe_n_out, 1'b1);
    check("post_rst_count", frame_count_out, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_display_scan_controller.md
# led_display_scan_controller

Sequences `led_display_driver_phy` to refresh the LED matrix with binary-coded-modulation (BCM) colour depth. For every row address and every bit plane, it does three things in order: fetches the plane row from the frame buffer, hands it to the phy over the row streaming handshake, and waits for the phy latch. It then drives the panel output-enable for a time weighted by the plane's significance. It sits between the frame buffer read port and the phy, and owns the panel OE pin.

## Interface
- `BIT_DEPTH`, 8: bit planes per colour channel (1..8).
- `BASE_ON_CYCLES`, 4: OE-on cycles for plane 0; plane p is on for `BASE_ON_CYCLES << p` cycles.
- `NUM_ROWS`, 16: row addresses scanned (1..16, 4-bit address).
- `clk_in`  in  1  the single clock for the block.
- `n_reset_in`  in  1  reset, asynchronous and active-low.
- `enable_in`  in  1  scanning enable, sampled only at frame boundaries and in IDLE.
- `fb_req_out`  out  1  one-cycle frame-buffer read request.
- `fb_row_out`  out  4  row address of the request.
- `fb_plane_out`  out  3  bit-plane index of the request.
- `fb_valid_in`  in  1  read data valid; arrives one or more cycles after `fb_req_out`.
- `fb_data_in`  in  `rgb_row_t`  plane row (top and bottom halves, one bit per pixel per colour).
- `row_valid_out`  out  1  one-cycle row push to the phy.
- `row_out`  out  `rgb_row_t`  registered row data to the phy.
- `row_address_out`  out  4  row address to the phy.
- `row_ready_in`  in  1  phy ready (phy `row_ready_out`).
- `latch_in`  in  1  phy latch pulse (phy `latch_out`).
- `oe_n_out`  out  1  panel output enable, active-low.
- `frame_done_out`  out  1  one-cycle pulse when a full frame has completed.
- `frame_count_out`  out  16  number of completed frames, wraps at 2^16.

## Operation
- States: IDLE, FETCH, WAIT_DATA, LOAD, SHIFT, SHOW, NEXT.
- IDLE: leaves for FETCH when `enable_in`=1, with row=0 and plane=0.
- FETCH: drives `fb_req_out`=1 for exactly one cycle, with `fb_row_out`/`fb_plane_out` set to the current row and plane. Goes to WAIT_DATA.
- WAIT_DATA: on `fb_valid_in`=1, registers `fb_data_in` into `row_out` and goes to LOAD. `fb_valid_in` in any other state is ignored.
- LOAD: when `row_ready_in`=1, drives `row_valid_out`=1 for one cycle with `row_address_out`=row, then goes to SHIFT. Otherwise it holds.
- SHIFT: waits for `latch_in`=1, then loads the on-counter with `(BASE_ON_CYCLES << plane) - 1` and goes to SHOW.
- SHOW: `oe_n_out`=0. The on-counter decrements each cycle; at 0 the block goes to NEXT.
- NEXT: `oe_n_out`=1 and the plane increments.
  - Plane wraps from `BIT_DEPTH-1` to 0 → row increments.
  - Row wraps from `NUM_ROWS-1` to 0 → `frame_done_out` pulses and `frame_count_out` increments in the same cycle. The block then goes to FETCH if `enable_in`=1, else to IDLE.
  - No frame wrap → goes to FETCH.
- On-counter width: `$clog2(BASE_ON_CYCLES << (BIT_DEPTH-1)) + 1`. No truncation is permitted.
- OE is never asserted outside SHOW, so the display is blank during fetch, shift and latch.
- `enable_in` deasserted mid-frame: the current frame completes, then the block enters IDLE.

## Timing
- Reset values: all outputs 0 except `oe_n_out`=1.
  - `row_out` is all zeros and `frame_count_out` is 0.
  - Assertion mid-operation forces IDLE and `oe_n_out`=1 immediately (asynchronous), with no request or push pending after release.
- All outputs are registered.
- `fb_req_out` is asserted in the cycle after entry to FETCH.
- `row_valid_out` is asserted no earlier than the cycle after `fb_valid_in` is captured, and only while `row_ready_in`=1.
- `latch_in` arrives about `GL_NUM_COL_PIXELS`+1 cycles after `row_valid_out` (phy-determined). `oe_n_out` falls the cycle after `latch_in` is seen.
- `oe_n_out` stays low for exactly `BASE_ON_CYCLES << plane` consecutive cycles.
- Simultaneous `latch_in` and `enable_in` changes: enable is honoured only in NEXT at the frame wrap.
- A `latch_in` outside SHIFT is ignored.

## Test plan
- **Reset:** assert `n_reset_in`=0 mid-SHOW → `oe_n_out`=1 at once; after release the state is IDLE, with `fb_req_out`=0, `row_valid_out`=0 and `frame_count_out`=0.
- **Single plane timing:** `BIT_DEPTH`=2, `BASE_ON_CYCLES`=2, fixed 1-cycle frame buffer, phy model → OE low for exactly 2 cycles on plane 0 and 4 cycles on plane 1, in that order.
- **Full scan:** `NUM_ROWS`=2 → requests in order (row,plane) (0,0),(0,1),(1,0),(1,1); `row_address_out` is 0,0,1,1; one `frame_done_out` pulse; `frame_count_out`=1.
- **Backpressure:** hold `row_ready_in`=0 for 10 cycles in LOAD → `row_valid_out` stays 0, `row_out` is stable, and the push occurs the first cycle ready=1.
- **Slow frame buffer:** `fb_valid_in` delayed by 5 cycles, plus a spurious `fb_valid_in` pulse during SHOW → correct data is pushed and the spurious pulse has no effect.
- **Enable drop:** deassert `enable_in` at row 0 → the frame finishes, then IDLE; `oe_n_out`=1 and no further `fb_req_out`.
- **Counter wrap:** force `frame_count_out` to 16'hFFFF → the next frame gives 0.
